// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: one req/addr_ok/data_ok transaction per load/store,
// with flush handling that cancels a pending request or discards an in-flight response.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_new,
  input  logic              mem_dram_re,
  input  logic              mem_dram_we,
  input  logic              mem_ex,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_wnum,
  input  logic              wb_allowin,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready_go,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshake: a request is offered while data_sram_req is high and is accepted on the
  // cycle data_sram_addr_ok is high; address/data/strobes stay stable until then and the
  // request is never withdrawn. data_sram_data_ok completes the single outstanding access.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_CANCEL = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic              need;
  logic              latch_en;
  logic              kill;
  logic              cflag;
  logic              pend;
  logic              go_pend;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              idle_go;

  assign need = mem_valid & mem_new & (mem_dram_re | mem_dram_we) & ~mem_ex & ~flush;

  // New instructions only arrive while the port is idle or draining a cancelled access.
  assign latch_en = need & ((state == S_IDLE) | (state == S_CANCEL));

  assign kill    = flush | cflag;
  assign go_pend = (pend & ~flush) | need;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (need) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (data_sram_addr_ok) state_nxt = kill ? S_CANCEL : S_WAIT;
      end
      S_WAIT: begin
        // A response coinciding with the flush is simply dropped; nothing left to drain.
        if (flush) state_nxt = data_sram_data_ok ? S_IDLE : S_CANCEL;
        else if (data_sram_data_ok) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (flush | wb_allowin) state_nxt = S_IDLE;
      end
      S_CANCEL: begin
        if (data_sram_data_ok) state_nxt = go_pend ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Cancel flag: remembers a flush seen while the request was still waiting for addr_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      cflag <= 1'b0;
    end else if ((state == S_REQ) & ~data_sram_addr_ok) begin
      cflag <= cflag | flush;
    end else begin
      cflag <= 1'b0;
    end
  end

  // Pending instruction that arrived while an old response was still being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      pend <= (state == S_CANCEL) & ~data_sram_data_ok & ~flush & (pend | need);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_en) begin
      wr_q    <= mem_dram_we;
      size_q  <= mem_wnum;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if ((state == S_WAIT) & data_sram_data_ok & ~flush & ~wr_q) begin
      rdata_q <= data_sram_rdata;
    end
  end

  assign idle_go = (state == S_IDLE) & mem_valid &
                   ((~need & ~(mem_dram_re | mem_dram_we)) | mem_ex);

  // Output logic
  always_comb begin
    data_sram_req   = (state == S_REQ);
    data_sram_wr    = wr_q;
    data_sram_size  = size_q;
    data_sram_addr  = addr_q;
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = wdata_q;
    case (size_q)
      2'd0: begin
        if (wr_q) data_sram_wstrb = 4'b0001 << addr_q[1:0];
        data_sram_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        if (wr_q) data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        if (wr_q) data_sram_wstrb = 4'b1111;
        data_sram_wdata = wdata_q;
      end
    endcase
    mem_rdata    = rdata_q;
    mem_ready_go = ((state == S_DONE) | idle_go) & ~flush;
    busy         = (state != S_IDLE);
    dbg_state    = state;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table-driven load/store vectors through a request scoreboard,
// plus hand-written flush, cancel, exception and reset sequences.
module tb_dmem_access_ctrl;

  localparam int REQ_W = 71;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_valid;
  logic        mem_new;
  logic        mem_dram_re;
  logic        mem_dram_we;
  logic        mem_ex;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wnum;
  logic        wb_allowin;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [31:0] mem_rdata;
  logic        mem_ready_go;
  logic        busy;
  logic [2:0]  dbg_state;

  dmem_access_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .mem_valid         (mem_valid),
    .mem_new           (mem_new),
    .mem_dram_re       (mem_dram_re),
    .mem_dram_we       (mem_dram_we),
    .mem_ex            (mem_ex),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wnum          (mem_wnum),
    .wb_allowin        (wb_allowin),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_rdata         (mem_rdata),
    .mem_ready_go      (mem_ready_go),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  wnum;
    logic [31:0] rdata;
    int          aok_dly;
    int          dok_dly;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[11];

  logic [REQ_W-1:0] exp_q[$];
  logic [31:0]      rd_q[$];
  logic [31:0]      model_rdata;
  int               pass_cnt = 0;
  int               chk_cnt  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [REQ_W-1:0] req_pack();
    return {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata};
  endfunction

  task automatic idle_inputs();
    flush = 1'b0; mem_valid = 1'b0; mem_new = 1'b0; mem_dram_re = 1'b0; mem_dram_we = 1'b0;
    mem_ex = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wnum = 2'd0; wb_allowin = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
  endtask

  task automatic drive_instr(input logic re, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] wnum);
    mem_valid = 1'b1; mem_new = 1'b1; mem_dram_re = re; mem_dram_we = we; mem_ex = 1'b0;
    mem_addr = addr; mem_wdata = wdata; mem_wnum = wnum;
  endtask

  // Driver for one table vector; expected request and load result go to the scoreboard.
  task automatic run_vec(input vec_t v);
    logic [REQ_W-1:0] exp;
    logic [31:0]      exp_rd;
    exp_q.push_back({v.we, v.wnum, v.addr, v.exp_wstrb, v.exp_wdata});
    exp_rd = v.we ? model_rdata : v.rdata;
    model_rdata = exp_rd;
    rd_q.push_back(exp_rd);
    drive_instr(v.re, v.we, v.addr, v.wdata, v.wnum);
    #1;
    check("vec_idle_req", data_sram_req, 0);
    check("vec_idle_ready_go", mem_ready_go, 0);
    tick();
    mem_new = 1'b0;
    mem_addr = $urandom; mem_wdata = $urandom; mem_wnum = 2'($urandom_range(0, 3));
    for (int i = 0; i < v.aok_dly; i++) begin
      #1;
      check("vec_req_held", data_sram_req, 1);
      check("vec_req_stable", req_pack(), exp_q[0]);
      tick();
    end
    data_sram_addr_ok = 1'b1;
    #1;
    check("vec_req", data_sram_req, 1);
    exp = exp_q.pop_front();
    check("vec_wr", data_sram_wr, exp[70]);
    check("vec_size", data_sram_size, exp[69:68]);
    check("vec_addr", data_sram_addr, exp[67:36]);
    check("vec_wstrb", data_sram_wstrb, exp[35:32]);
    check("vec_wdata", data_sram_wdata, exp[31:0]);
    tick();
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < v.dok_dly; i++) begin
      #1;
      check("vec_wait_no_req", data_sram_req, 0);
      check("vec_wait_ready_go", mem_ready_go, 0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = v.rdata;
    #1;
    check("vec_wait_no_req", data_sram_req, 0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = $urandom;
    #1;
    check("vec_ready_go", mem_ready_go, 1);
    exp_rd = rd_q.pop_front();
    check("vec_rdata", mem_rdata, exp_rd);
    data_sram_data_ok = 1'b1;
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("vec_done_hold_go", mem_ready_go, 1);
    check("vec_done_hold_rdata", mem_rdata, exp_rd);
    wb_allowin = 1'b1;
    tick();
    wb_allowin = 1'b0; mem_valid = 1'b0; mem_dram_re = 1'b0; mem_dram_we = 1'b0;
    #1;
    check("vec_back_idle", busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h00001000, 32'h00000000, 2'd2, 32'hDEADBEEF, 0, 0, 4'b0000, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 32'h00002003, 32'h000000A5, 2'd0, 32'h00000000, 0, 0, 4'b1000, 32'hA5A5A5A5};
    vecs[2]  = '{1'b0, 1'b1, 32'h00002002, 32'h00001234, 2'd1, 32'h00000000, 0, 0, 4'b1100, 32'h12341234};
    vecs[3]  = '{1'b1, 1'b0, 32'h00003004, 32'h00000000, 2'd2, 32'h13579BDF, 3, 1, 4'b0000, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b1, 32'h00004000, 32'h1234567F, 2'd0, 32'h00000000, 1,
                 int'($urandom_range(0, 3)), 4'b0001, 32'h7F7F7F7F};
    vecs[5]  = '{1'b0, 1'b1, 32'h00004000, 32'hFFFFBEEF, 2'd1, 32'h00000000, 0,
                 int'($urandom_range(0, 3)), 4'b0011, 32'hBEEFBEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h00005008, 32'hCAFEF00D, 2'd2, 32'h00000000, 1, 2, 4'b1111, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b0, 32'h00006001, 32'h00000000, 2'd0, 32'h0BADF00D, 2, 0, 4'b0000, 32'h00000000};
    vecs[8]  = '{1'b0, 1'b1, 32'h00007000, 32'h89ABCDEF, 2'd3, 32'h00000000, 0, 1, 4'b1111, 32'h89ABCDEF};
    vecs[9]  = '{1'b0, 1'b1, 32'h00002001, 32'h0000003C, 2'd0, 32'h00000000, 0, 0, 4'b0010, 32'h3C3C3C3C};
    vecs[10] = '{1'b1, 1'b0, 32'h00008010, 32'h00000000, 2'd1, 32'h76543210, 0, 0, 4'b0000, 32'h00000000};

    idle_inputs();
    model_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_req", data_sram_req, 0);
    check("rst_req_fields", req_pack(), '0);
    check("rst_rdata", mem_rdata, 0);
    check("rst_ready_go", mem_ready_go, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Flush in WAIT, new load arrives during CANCEL, old response dropped.
    drive_instr(1'b1, 1'b0, 32'h00008000, 32'h0, 2'd2);
    tick();
    mem_new = 1'b0;
    #1;
    check("a_req", data_sram_req, 1);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; flush = 1'b1;
    #1;
    check("a_flush_ready_go", mem_ready_go, 0);
    tick();
    flush = 1'b0;
    drive_instr(1'b1, 1'b0, 32'h00009000, 32'h0, 2'd2);
    #1;
    check("a_cancel_no_req", data_sram_req, 0);
    check("a_cancel_busy", busy, 1);
    check("a_cancel_ready_go", mem_ready_go, 0);
    tick();
    mem_new = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
    #1;
    check("a_drain_no_req", data_sram_req, 0);
    check("a_drain_ready_go", mem_ready_go, 0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("a_new_req", data_sram_req, 1);
    check("a_new_addr", data_sram_addr, 32'h00009000);
    check("a_old_dropped", mem_rdata, model_rdata);
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h22222222;
    tick();
    data_sram_data_ok = 1'b0;
    model_rdata = 32'h22222222;
    #1;
    check("a_ready_go", mem_ready_go, 1);
    check("a_rdata", mem_rdata, model_rdata);
    wb_allowin = 1'b1;
    tick();
    wb_allowin = 1'b0; mem_valid = 1'b0;
    #1;
    check("a_idle", busy, 0);

    // Flush while REQ waits for addr_ok: request held, then cancelled and drained.
    drive_instr(1'b1, 1'b0, 32'h0000A000, 32'h0, 2'd2);
    tick();
    mem_new = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; mem_valid = 1'b0;
    #1;
    check("b_req_held", data_sram_req, 1);
    check("b_addr_held", data_sram_addr, 32'h0000A000);
    tick();
    data_sram_addr_ok = 1'b1;
    #1;
    check("b_req_still", data_sram_req, 1);
    tick();
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33333333;
    #1;
    check("b_cancel_no_req", data_sram_req, 0);
    check("b_cancel_busy", busy, 1);
    check("b_cancel_ready_go", mem_ready_go, 0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("b_idle", busy, 0);
    check("b_rdata_kept", mem_rdata, model_rdata);

    // Exception load and plain instruction: immediate ready_go, gated by flush.
    drive_instr(1'b1, 1'b0, 32'h0000C000, 32'h0, 2'd2);
    mem_ex = 1'b1;
    #1;
    check("c_ex_ready_go", mem_ready_go, 1);
    check("c_ex_no_req", data_sram_req, 0);
    tick();
    mem_ex = 1'b0; mem_new = 1'b0; mem_dram_re = 1'b0;
    #1;
    check("c_ex_stays_idle", busy, 0);
    check("c_alu_ready_go", mem_ready_go, 1);
    flush = 1'b1;
    #1;
    check("c_flush_ready_go", mem_ready_go, 0);
    flush = 1'b0; mem_valid = 1'b0;

    // Reset during WAIT, then a late data_ok in IDLE.
    drive_instr(1'b0, 1'b1, 32'h0000B002, 32'h5A5A5A5A, 2'd2);
    tick();
    mem_new = 1'b0; mem_valid = 1'b0; mem_dram_we = 1'b0;
    data_sram_addr_ok = 1'b1;
    tick();
    data_sram_addr_ok = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    model_rdata = 32'h0;
    #1;
    check("d_rst_req", data_sram_req, 0);
    check("d_rst_fields", req_pack(), '0);
    check("d_rst_rdata", mem_rdata, 0);
    check("d_rst_busy", busy, 0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h44444444;
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("d_late_ok_idle", busy, 0);
    check("d_late_ok_rdata", mem_rdata, model_rdata);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
